veer_trace_fifo: RTL and testbench
==================================

Name: veer_trace_fifo

Overview:
- Parametrised successor to the fixed 3-lane trace_pkt_t retire-trace interface.
- Accepts up to NLANES retired instructions per cycle from the decode/TLU trace outputs.
- Buffers them as per-instruction records and drains one record per cycle to an external trace sink over a valid/ready handshake.
- Handles overflow by dropping whole retire groups, marking the discontinuity, and counting the drops.

Parameters:
- NLANES, 3: retire lanes per cycle, 1..4.
- DEPTH, 8: FIFO entries; power of two; must be >= NLANES.
- CNTW, 16: width of the dropped-group counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- trace_en  in  1  enqueue enable; when low, no enqueue and FIFO drains normally.
- trace_valid_ip  in  NLANES  per-lane retire valid.
- trace_insn_ip  in  NLANES*32  lane i occupies [32i+31:32i].
- trace_address_ip  in  NLANES*32  lane PC, same packing.
- trace_exception_ip  in  NLANES  per-lane exception.
- trace_interrupt_ip  in  NLANES  per-lane interrupt.
- trace_ecause_ip  in  5  cause; belongs to the lane with exception or interrupt set.
- trace_tval_ip  in  32  tval; same ownership as ecause.
- trc_valid  out  1  output record valid.
- trc_ready  in  1  sink accepts record.
- trc_insn  out  32  record instruction.
- trc_addr  out  32  record PC.
- trc_exc  out  1  record exception flag.
- trc_intr  out  1  record interrupt flag.
- trc_ecause  out  5  cause; 0 unless trc_exc or trc_intr.
- trc_tval  out  32  tval; 0 unless trc_exc or trc_intr.
- trc_gap  out  1  one or more groups were dropped immediately before this record.
- trc_ovf_cnt  out  CNTW  dropped-group count, saturating.
- trc_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, rst=1): wr/rd pointers 0, count 0, pending_gap 0, ovf counter 0. All outputs 0 (data outputs are gated by trc_valid). Record storage is not reset.
- Group: n = popcount(trace_valid_ip & {NLANES{trace_en}}). n=0 means no enqueue.
- Enqueue condition: n <= DEPTH - count, using the registered count at cycle start.
  - A pop in the same cycle does not create space for that cycle's push.
- Accepted group: valid lanes are written in ascending lane index to consecutive slots (wr_ptr, wr_ptr+1, ...), wrapping mod DEPTH. Invalid lanes are compacted out.
- Record fields: ecause/tval are stored for a lane only if its exception or interrupt bit is set; otherwise 0.
- Gap marking: the first record of an accepted group carries gap=pending_gap, then pending_gap clears. All other records have gap=0.
- Drop: when n>0 and n > free, the whole group is discarded (no partial writes). pending_gap is set and the ovf counter increments, saturating at 2^CNTW-1. Multiple consecutive drops produce a single gap mark.
- Output: trc_valid = (count != 0). Data is read combinationally from rd_ptr.
  - Pop occurs when trc_valid & trc_ready; rd_ptr advances by 1 with wrap.
  - Data is held stable while trc_valid & !trc_ready.
- Latency: a group accepted at edge N is visible on trc_valid after edge N; first pop possible in cycle N+1. No bypass from input to output.
- Count update: count_next = count + (accepted ? n : 0) - pop. Simultaneous push and pop is legal at any occupancy.
- Full: count==DEPTH means any n>0 drops. Empty: trc_valid=0 and trc_ready is ignored.
- trace_en low: no enqueue and no drop/counting; draining continues. pending_gap is held.
- Reset asserted mid-transfer: immediate clear; buffered records are lost. No gap is flagged after reset.

Test Plan:
- NLANES=3, DEPTH=8, trc_ready=1; single retire, lane0 insn=0x00000013, addr=0x1000 → trc_valid 1 cycle later, trc_insn=0x13, trc_addr=0x1000, gap=0, count 1→0.
- valid_ip=3'b101, lane0 addr=0x2000, lane2 addr=0x2008, ready=1 → two records in order 0x2000 then 0x2008, on back-to-back cycles.
- ready=0, three full groups (9 instrs) → first two groups accepted (count=6); third group (n=3 > free=2) dropped, ovf_cnt=1. Next accepted group's first record has trc_gap=1; the following records have gap=0.
- count=7, ready=1, n=1 and pop in same cycle → accepted, count stays 7. Same with n=2 → dropped, count=6.
- lane1 exception=1, ecause=5'd2, tval=0xDEADBEEF, lane0 clean → lane0 record has ecause=0, tval=0; lane1 record has exc=1, ecause=2, tval=0xDEADBEEF.
- Force ovf to 0xFFFF, drop again → stays 0xFFFF. Assert rst with count=5 → trc_valid=0, count=0, ovf_cnt=0 asynchronously.

Source files
------------

// File: rtl/veer_trace_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | veer_trace_fifo: multi-lane retire trace -> per-instruction record FIFO    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module veer_trace_fifo #(
  parameter int NLANES = 3,
  parameter int DEPTH  = 8,
  parameter int CNTW   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trace_en,
  input  logic [NLANES-1:0]         trace_valid_ip,
  input  logic [NLANES*32-1:0]      trace_insn_ip,
  input  logic [NLANES*32-1:0]      trace_address_ip,
  input  logic [NLANES-1:0]         trace_exception_ip,
  input  logic [NLANES-1:0]         trace_interrupt_ip,
  input  logic [4:0]                trace_ecause_ip,
  input  logic [31:0]               trace_tval_ip,
  output logic                      trc_valid,
  input  logic                      trc_ready,
  output logic [31:0]               trc_insn,
  output logic [31:0]               trc_addr,
  output logic                      trc_exc,
  output logic                      trc_intr,
  output logic [4:0]                trc_ecause,
  output logic [31:0]               trc_tval,
  output logic                      trc_gap,
  output logic [CNTW-1:0]           trc_ovf_cnt,
  output logic [$clog2(DEPTH):0]    trc_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   C_DEPTH    = CW'(DEPTH);
  localparam logic [AW-1:0]   C_PTR_MASK = AW'(DEPTH - 1);
  localparam logic [CNTW-1:0] C_OVF_MAX  = '1;

  if (DEPTH < NLANES) begin : g_depth_chk
    $error("veer_trace_fifo: DEPTH must be >= NLANES");
  end

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pending_gap_q, pending_gap_d;
  logic [CNTW-1:0] ovf_q, ovf_d;

  logic [31:0]     rec_insn_q   [DEPTH];
  logic [31:0]     rec_addr_q   [DEPTH];
  logic            rec_exc_q    [DEPTH];
  logic            rec_intr_q   [DEPTH];
  logic [4:0]      rec_ecause_q [DEPTH];
  logic [31:0]     rec_tval_q   [DEPTH];
  logic            rec_gap_q    [DEPTH];

  logic [NLANES-1:0] lane_vld;
  logic [AW-1:0]     lane_off [NLANES];
  logic [AW-1:0]     lane_idx [NLANES];
  logic [CW-1:0]     grp_n;
  logic [CW-1:0]     free_slots;
  logic              accept, drop, pop;

  assign lane_vld = trace_valid_ip & {NLANES{trace_en}};

  // Compaction: each valid lane's slot offset is the number of valid lanes below it.
  always_comb begin
    grp_n = '0;
    for (int i = 0; i < NLANES; i++) begin
      lane_off[i] = grp_n[AW-1:0];
      lane_idx[i] = (wr_ptr_q + grp_n[AW-1:0]) & C_PTR_MASK;
      grp_n       = grp_n + CW'(lane_vld[i]);
    end
  end

  // Free space is taken from the registered count; a same-cycle pop does not help.
  assign free_slots = C_DEPTH - count_q;
  assign accept     = (grp_n != '0) && (grp_n <= free_slots);
  assign drop       = (grp_n != '0) && (grp_n > free_slots);
  assign pop        = (count_q != '0) && trc_ready;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q + (accept ? grp_n : '0) - CW'(pop);
    pending_gap_d = pending_gap_q;
    ovf_d         = ovf_q;
    if (accept) begin
      wr_ptr_d      = (wr_ptr_q + grp_n[AW-1:0]) & C_PTR_MASK;
      pending_gap_d = 1'b0;
    end
    if (drop) begin
      pending_gap_d = 1'b1;
      if (ovf_q != C_OVF_MAX) ovf_d = ovf_q + 1'b1;
    end
    if (pop) rd_ptr_d = (rd_ptr_q + 1'b1) & C_PTR_MASK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pending_gap_q <= 1'b0;
      ovf_q         <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pending_gap_q <= pending_gap_d;
      ovf_q         <= ovf_d;
    end
  end

  // Record storage is deliberately unreset; only occupancy makes it visible.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NLANES; i++) begin
        if (lane_vld[i]) begin
          rec_insn_q[lane_idx[i]]   <= trace_insn_ip[32*i +: 32];
          rec_addr_q[lane_idx[i]]   <= trace_address_ip[32*i +: 32];
          rec_exc_q[lane_idx[i]]    <= trace_exception_ip[i];
          rec_intr_q[lane_idx[i]]   <= trace_interrupt_ip[i];
          rec_ecause_q[lane_idx[i]] <= (trace_exception_ip[i] | trace_interrupt_ip[i])
                                       ? trace_ecause_ip : 5'd0;
          rec_tval_q[lane_idx[i]]   <= (trace_exception_ip[i] | trace_interrupt_ip[i])
                                       ? trace_tval_ip : 32'd0;
          rec_gap_q[lane_idx[i]]    <= (lane_off[i] == '0) ? pending_gap_q : 1'b0;
        end
      end
    end
  end

  assign trc_valid   = (count_q != '0);
  assign trc_insn    = trc_valid ? rec_insn_q[rd_ptr_q]   : 32'd0;
  assign trc_addr    = trc_valid ? rec_addr_q[rd_ptr_q]   : 32'd0;
  assign trc_exc     = trc_valid ? rec_exc_q[rd_ptr_q]    : 1'b0;
  assign trc_intr    = trc_valid ? rec_intr_q[rd_ptr_q]   : 1'b0;
  assign trc_ecause  = trc_valid ? rec_ecause_q[rd_ptr_q] : 5'd0;
  assign trc_tval    = trc_valid ? rec_tval_q[rd_ptr_q]   : 32'd0;
  assign trc_gap     = trc_valid ? rec_gap_q[rd_ptr_q]    : 1'b0;
  assign trc_ovf_cnt = ovf_q;
  assign trc_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_veer_trace_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_veer_trace_fifo: randomized + directed bench with queue reference model |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_veer_trace_fifo;

  localparam int NL = 3;
  localparam int DP = 8;
  localparam int CN = 4;                  // narrow counter so saturation is reachable quickly
  localparam int OVF_MAX = (1 << CN) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            trace_en = 1'b0;
  logic [NL-1:0]   trace_valid_ip = '0;
  logic [NL*32-1:0] trace_insn_ip = '0;
  logic [NL*32-1:0] trace_address_ip = '0;
  logic [NL-1:0]   trace_exception_ip = '0;
  logic [NL-1:0]   trace_interrupt_ip = '0;
  logic [4:0]      trace_ecause_ip = '0;
  logic [31:0]     trace_tval_ip = '0;
  logic            trc_ready = 1'b0;
  logic            trc_valid;
  logic [31:0]     trc_insn, trc_addr, trc_tval;
  logic            trc_exc, trc_intr, trc_gap;
  logic [4:0]      trc_ecause;
  logic [CN-1:0]   trc_ovf_cnt;
  logic [$clog2(DP):0] trc_count;

  veer_trace_fifo #(.NLANES(NL), .DEPTH(DP), .CNTW(CN)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en),
    .trace_valid_ip(trace_valid_ip), .trace_insn_ip(trace_insn_ip),
    .trace_address_ip(trace_address_ip), .trace_exception_ip(trace_exception_ip),
    .trace_interrupt_ip(trace_interrupt_ip), .trace_ecause_ip(trace_ecause_ip),
    .trace_tval_ip(trace_tval_ip), .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_insn(trc_insn), .trc_addr(trc_addr), .trc_exc(trc_exc), .trc_intr(trc_intr),
    .trc_ecause(trc_ecause), .trc_tval(trc_tval), .trc_gap(trc_gap),
    .trc_ovf_cnt(trc_ovf_cnt), .trc_count(trc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic        intr;
    logic [4:0]  ecause;
    logic [31:0] tval;
    logic        gap;
  } rec_t;

  rec_t m_q[$];
  bit   m_gap;
  int   m_ovf;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs();
    rec_t e;
    e = '{default: '0};
    if (m_q.size() > 0) e = m_q[0];
    chk_eq("valid",  64'(trc_valid),   64'(m_q.size() != 0));
    chk_eq("count",  64'(trc_count),   64'(m_q.size()));
    chk_eq("ovf",    64'(trc_ovf_cnt), 64'(m_ovf));
    chk_eq("insn",   64'(trc_insn),    64'(e.insn));
    chk_eq("addr",   64'(trc_addr),    64'(e.addr));
    chk_eq("exc",    64'(trc_exc),     64'(e.exc));
    chk_eq("intr",   64'(trc_intr),    64'(e.intr));
    chk_eq("ecause", 64'(trc_ecause),  64'(e.ecause));
    chk_eq("tval",   64'(trc_tval),    64'(e.tval));
    chk_eq("gap",    64'(trc_gap),     64'(e.gap));
  endtask

  // Reference behaviour for one clock edge, using the inputs held across it.
  task automatic model_step();
    int  n, free_n;
    bit  first;
    rec_t r;
    if (rst) begin
      m_q.delete(); m_gap = 0; m_ovf = 0;
      return;
    end
    n = 0;
    if (trace_en) for (int i = 0; i < NL; i++) n += int'(trace_valid_ip[i]);
    free_n = DP - m_q.size();
    if (m_q.size() > 0 && trc_ready) void'(m_q.pop_front());
    if (n > 0 && n <= free_n) begin
      first = 1;
      for (int i = 0; i < NL; i++) begin
        if (trace_valid_ip[i]) begin
          r.insn   = trace_insn_ip[32*i +: 32];
          r.addr   = trace_address_ip[32*i +: 32];
          r.exc    = trace_exception_ip[i];
          r.intr   = trace_interrupt_ip[i];
          r.ecause = (r.exc || r.intr) ? trace_ecause_ip : 5'd0;
          r.tval   = (r.exc || r.intr) ? trace_tval_ip : 32'd0;
          r.gap    = first ? m_gap : 1'b0;
          first    = 0;
          m_q.push_back(r);
        end
      end
      m_gap = 0;
    end else if (n > 0) begin
      m_gap = 1;
      if (m_ovf < OVF_MAX) m_ovf++;
    end
  endtask

  task automatic cycle();
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_lane(input int i, input logic [31:0] insn, input logic [31:0] addr,
                          input logic exc, input logic intr);
    trace_insn_ip[32*i +: 32]    = insn;
    trace_address_ip[32*i +: 32] = addr;
    trace_exception_ip[i]        = exc;
    trace_interrupt_ip[i]        = intr;
  endtask

  task automatic push_group(input logic [NL-1:0] vld, input logic [31:0] base);
    trace_en = 1'b1;
    trace_valid_ip = vld;
    for (int i = 0; i < NL; i++) set_lane(i, base + 32'(i), base + 32'(4*i), 1'b0, 1'b0);
    cycle();
  endtask

  task automatic idle(input int k);
    trace_valid_ip = '0;
    trace_exception_ip = '0;
    trace_interrupt_ip = '0;
    for (int i = 0; i < k; i++) cycle();
  endtask

  initial begin
    m_gap = 0; m_ovf = 0;
    repeat (2) @(negedge clk);
    chk_eq("rst_valid", 64'(trc_valid), 64'd0);
    chk_eq("rst_count", 64'(trc_count), 64'd0);
    chk_eq("rst_ovf",   64'(trc_ovf_cnt), 64'd0);
    rst = 1'b0;
    trc_ready = 1'b1;

    // single retire, then a compacted 3'b101 group
    trace_en = 1'b1;
    trace_valid_ip = 3'b001;
    set_lane(0, 32'h13, 32'h1000, 1'b0, 1'b0);
    cycle();
    chk_eq("single_insn", 64'(trc_insn), 64'h13);
    chk_eq("single_addr", 64'(trc_addr), 64'h1000);
    idle(2);
    trace_valid_ip = 3'b101;
    set_lane(0, 32'h11, 32'h2000, 1'b0, 1'b0);
    set_lane(2, 32'h22, 32'h2008, 1'b0, 1'b0);
    cycle();
    idle(3);

    // overflow: two groups fit, third dropped, then gap on next accepted group
    trc_ready = 1'b0;
    push_group(3'b111, 32'h100);
    push_group(3'b111, 32'h200);
    push_group(3'b111, 32'h300);
    chk_eq("ovf_one", 64'(trc_ovf_cnt), 64'd1);
    push_group(3'b011, 32'h400);
    trc_ready = 1'b1;
    idle(10);

    // count=7 with simultaneous pop: n=1 accepted, n=2 dropped
    trc_ready = 1'b0;
    push_group(3'b111, 32'h500);
    push_group(3'b111, 32'h600);
    push_group(3'b001, 32'h700);
    trc_ready = 1'b1;
    push_group(3'b010, 32'h800);
    chk_eq("cnt7_hold", 64'(trc_count), 64'd7);
    push_group(3'b110, 32'h900);
    chk_eq("cnt7_drop", 64'(trc_count), 64'd6);
    idle(8);

    // exception ownership of ecause/tval
    trace_valid_ip = 3'b011;
    set_lane(0, 32'hA0, 32'h3000, 1'b0, 1'b0);
    set_lane(1, 32'hA1, 32'h3004, 1'b1, 1'b0);
    trace_ecause_ip = 5'd2;
    trace_tval_ip = 32'hDEADBEEF;
    cycle();
    idle(3);

    // counter saturation, then async reset with buffered records
    trc_ready = 1'b0;
    for (int i = 0; i < 3 + OVF_MAX + 3; i++) push_group(3'b111, 32'(i * 16));
    chk_eq("ovf_sat", 64'(trc_ovf_cnt), 64'(OVF_MAX));
    trc_ready = 1'b1;
    idle(3);
    trc_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_eq("arst_valid", 64'(trc_valid), 64'd0);
    chk_eq("arst_count", 64'(trc_count), 64'd0);
    chk_eq("arst_ovf",   64'(trc_ovf_cnt), 64'd0);
    m_q.delete(); m_gap = 0; m_ovf = 0;
    @(negedge clk);
    cycle();
    rst = 1'b0;
    push_group(3'b001, 32'hBEE0);
    chk_eq("post_rst_gap", 64'(trc_gap), 64'd0);

    // randomized traffic with phases of back-pressure
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) trc_ready = 1'b1;
      trc_ready = ((c / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      trace_en = ($urandom_range(0, 7) != 0);
      trace_valid_ip = NL'($urandom);
      for (int i = 0; i < NL; i++)
        set_lane(i, $urandom, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
      trace_ecause_ip = 5'($urandom);
      trace_tval_ip = $urandom;
      cycle();
    end
    trc_ready = 1'b1;
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
